// File: rtl/cache_l1_refill_ctrl_if.sv
// L2-side request/response bus of the L1 refill controller.
// The controller is the master: it issues write-backs and fills, and L2 acknowledges.
interface cache_l1_refill_ctrl_if #(
  parameter int BADDR_W = 15,
  parameter int BLOCK_W = 128
);
  logic               l2_req_o;
  logic               l2_we_o;
  logic [BADDR_W-1:0] l2_addr_o;
  logic [BLOCK_W-1:0] l2_wdata_o;
  logic               l2_ack_i;
  logic [BLOCK_W-1:0] l2_rdata_i;

  modport master (
    output l2_req_o, l2_we_o, l2_addr_o, l2_wdata_o,
    input  l2_ack_i, l2_rdata_i
  );

  modport slave (
    input  l2_req_o, l2_we_o, l2_addr_o, l2_wdata_o,
    output l2_ack_i, l2_rdata_i
  );
endinterface

// File: rtl/cache_l1_refill_ctrl.sv
// L1 data-cache miss handler: optional dirty-victim write-back to L2, block fill
// from L2, then a single block write into the L1 data array.
//
// state      | meaning
// IDLE       | waiting for a core load/store; latches the request address
// LOOKUP     | L1 hit/victim status for the latched address is sampled
// WB_WAIT    | dirty victim block being written back to L2
// FILL_WAIT  | missing block being read from L2
// FILL_WRITE | one-cycle block write of the fetched data into L1
module cache_l1_refill_ctrl #(
  parameter int block_size  = 128,
  parameter int tag_size    = 9,
  parameter int idx_size    = 6,
  parameter int word_size   = 2,
  parameter int offset_size = 2,
  localparam int ADDR_W     = tag_size + idx_size + word_size + offset_size,
  localparam int BADDR_W    = tag_size + idx_size
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_read_i,
  input  logic                  req_write_i,
  input  logic [ADDR_W-1:0]     req_addr_i,
  output logic                  stall_o,
  input  logic                  hit_i,
  input  logic                  victim_dirty_i,
  input  logic [tag_size-1:0]   victim_tag_i,
  input  logic [block_size-1:0] l1_block_i,
  output logic                  l1_write_o,
  output logic                  l1_write_L2_o,
  output logic [ADDR_W-1:0]     l1_addr_o,
  output logic [block_size-1:0] l1_data_L2_o,
  cache_l1_refill_ctrl_if.master l2,
  output logic [15:0]           miss_cnt_o,
  output logic [15:0]           wb_cnt_o
);

  localparam int LO = word_size + offset_size;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOOKUP     = 3'd1,
    WB_WAIT    = 3'd2,
    FILL_WAIT  = 3'd3,
    FILL_WRITE = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [tag_size-1:0]   victim_tag_q, victim_tag_d;
  logic [block_size-1:0] victim_blk_q, victim_blk_d;
  logic [block_size-1:0] fill_q, fill_d;
  logic [15:0]           miss_cnt_q, miss_cnt_d;
  logic [15:0]           wb_cnt_q, wb_cnt_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      victim_tag_q <= '0;
      victim_blk_q <= '0;
      fill_q       <= '0;
      miss_cnt_q   <= '0;
      wb_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      victim_tag_q <= victim_tag_d;
      victim_blk_q <= victim_blk_d;
      fill_q       <= fill_d;
      miss_cnt_q   <= miss_cnt_d;
      wb_cnt_q     <= wb_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    victim_tag_d = victim_tag_q;
    victim_blk_d = victim_blk_q;
    fill_d       = fill_q;
    miss_cnt_d   = miss_cnt_q;
    wb_cnt_d     = wb_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (req_read_i || req_write_i) begin
          addr_d  = req_addr_i;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit_i) begin
          state_d = IDLE;
        end else begin
          miss_cnt_d = sat_inc(miss_cnt_q);
          if (victim_dirty_i) begin
            // Victim is captured now: the fill will overwrite the L1 line it came from.
            victim_tag_d = victim_tag_i;
            victim_blk_d = l1_block_i;
            wb_cnt_d     = sat_inc(wb_cnt_q);
            state_d      = WB_WAIT;
          end else begin
            state_d = FILL_WAIT;
          end
        end
      end
      WB_WAIT: begin
        if (l2.l2_ack_i) state_d = FILL_WAIT;
      end
      FILL_WAIT: begin
        if (l2.l2_ack_i) begin
          fill_d  = l2.l2_rdata_i;
          state_d = FILL_WRITE;
        end
      end
      FILL_WRITE: state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // All outputs decode from registered state only; ack never reaches req combinationally.
  always_comb begin
    stall_o        = (state_q != IDLE);
    l1_write_o     = 1'b0;
    l1_write_L2_o  = 1'b0;
    l1_data_L2_o   = '0;
    l2.l2_req_o    = 1'b0;
    l2.l2_we_o     = 1'b0;
    l2.l2_addr_o   = '0;
    l2.l2_wdata_o  = '0;

    unique case (state_q)
      WB_WAIT: begin
        l2.l2_req_o   = 1'b1;
        l2.l2_we_o    = 1'b1;
        l2.l2_addr_o  = {victim_tag_q, addr_q[LO +: idx_size]};
        l2.l2_wdata_o = victim_blk_q;
      end
      FILL_WAIT: begin
        l2.l2_req_o  = 1'b1;
        l2.l2_addr_o = addr_q[ADDR_W-1:LO];
      end
      FILL_WRITE: begin
        l1_write_o    = 1'b1;
        l1_write_L2_o = 1'b1;
        l1_data_L2_o  = fill_q;
      end
      default: ;
    endcase
  end

  assign l1_addr_o  = addr_q;
  assign miss_cnt_o = miss_cnt_q;
  assign wb_cnt_o   = wb_cnt_q;

endmodule
